// File: rtl/vga_capture_if.sv
// Video link between an SVGA source and the capture block: raw syncs/pixels in,
// recovered pixel stream and timing status out.
interface vga_capture_if;
  logic        vga_hsync;
  logic        vga_vsync;
  logic [15:0] vga_rgb;
  logic        pix_de;
  logic [10:0] pix_x;
  logic [9:0]  pix_y;
  logic [15:0] pix_rgb;
  logic        frame_start;
  logic        locked;
  logic        timing_err;

  modport master (
    output vga_hsync, vga_vsync, vga_rgb,
    input  pix_de, pix_x, pix_y, pix_rgb, frame_start, locked, timing_err
  );

  modport slave (
    input  vga_hsync, vga_vsync, vga_rgb,
    output pix_de, pix_x, pix_y, pix_rgb, frame_start, locked, timing_err
  );
endinterface

// File: rtl/vga_capture.sv
// VGA receive side: recovers pixel coordinates from hsync/vsync, verifies line and
// frame lengths, and emits the active pixel stream once timing is locked.
module vga_capture #(
  parameter int unsigned H_SYNC   = 128,
  parameter int unsigned H_BP     = 88,
  parameter int unsigned H_ACTIVE = 800,
  parameter int unsigned H_TOTAL  = 1056,
  parameter int unsigned V_SYNC   = 4,
  parameter int unsigned V_BP     = 23,
  parameter int unsigned V_ACTIVE = 600,
  parameter int unsigned V_TOTAL  = 628,
  parameter bit          SYNC_POL = 1'b1
) (
  input logic         sclk,
  input logic         s_rst,
  vga_capture_if.slave bus
);
  localparam logic [10:0] H_LAST      = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_LEN       = 11'(H_TOTAL);
  localparam logic [10:0] H_FIRST_PIX = 11'(H_SYNC + H_BP);
  localparam logic [10:0] H_LAST_PIX  = 11'(H_SYNC + H_BP + H_ACTIVE - 1);
  localparam logic [10:0] H_MAX       = 11'h7ff;
  localparam logic [9:0]  V_LAST      = 10'(V_TOTAL - 1);
  localparam logic [9:0]  V_LEN       = 10'(V_TOTAL);
  localparam logic [9:0]  V_FIRST_PIX = 10'(V_SYNC + V_BP);
  localparam logic [9:0]  V_LAST_PIX  = 10'(V_SYNC + V_BP + V_ACTIVE - 1);
  localparam logic [9:0]  V_MAX       = 10'h3ff;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t      state, state_next;
  logic        hs1, vs1, hs_prev, vs_at_hle;
  logic [15:0] rgb1;
  logic [10:0] h_cnt, h_next;
  logic [9:0]  v_cnt, v_next;
  logic        hle, vle, line_err, frame_err, err, in_window, de_next;

  always_comb begin
    // NOTE: every signal gets a value before any branch so no path can infer a latch.
    state_next = state;
    hle        = hs1 & ~hs_prev;
    vle        = hle & vs1 & ~vs_at_hle;
    h_next     = hle ? 11'd0 : ((h_cnt == H_MAX) ? h_cnt : h_cnt + 11'd1);
    v_next     = v_cnt;
    if (hle) v_next = vle ? 10'd0 : ((v_cnt == V_MAX) ? v_cnt : v_cnt + 10'd1);

    // A line must end exactly at H_TOTAL clocks; a frame exactly at V_TOTAL lines.
    line_err  = hle ? (h_cnt != H_LAST) : (h_next == H_LEN);
    frame_err = vle ? (v_cnt != V_LAST) : (hle && (v_next == V_LEN));
    err       = (state != SEARCH) && (line_err || frame_err);

    case (state)
      SEARCH:  if (vle) state_next = VERIFY;
      VERIFY:  if (err) state_next = SEARCH;
               else if (vle) state_next = LOCKED;
      LOCKED:  if (err) state_next = SEARCH;
      default: state_next = SEARCH;
    endcase

    in_window = (h_next >= H_FIRST_PIX) && (h_next <= H_LAST_PIX) &&
                (v_next >= V_FIRST_PIX) && (v_next <= V_LAST_PIX);
    de_next   = (state_next == LOCKED) && in_window;
  end

  always_ff @(posedge sclk or posedge s_rst) begin
    if (s_rst) begin
      hs1             <= 1'b0;
      vs1             <= 1'b0;
      rgb1            <= '0;
      hs_prev         <= 1'b0;
      vs_at_hle       <= 1'b0;
      h_cnt           <= '0;
      v_cnt           <= '0;
      state           <= SEARCH;
      bus.pix_de      <= 1'b0;
      bus.pix_x       <= '0;
      bus.pix_y       <= '0;
      bus.pix_rgb     <= '0;
      bus.frame_start <= 1'b0;
      bus.locked      <= 1'b0;
      bus.timing_err  <= 1'b0;
    end else begin
      // NOTE: non-blocking throughout so every register sees pre-edge values of the others.
      hs1       <= bus.vga_hsync ^ ~SYNC_POL;
      vs1       <= bus.vga_vsync ^ ~SYNC_POL;
      rgb1      <= bus.vga_rgb;
      hs_prev   <= hs1;
      if (hle) vs_at_hle <= vs1;
      h_cnt     <= h_next;
      v_cnt     <= v_next;
      state     <= state_next;

      bus.timing_err  <= (state == LOCKED) && err;
      bus.locked      <= (state_next == LOCKED);
      bus.pix_de      <= de_next;
      bus.frame_start <= de_next && (h_next == H_FIRST_PIX) && (v_next == V_FIRST_PIX);
      if (de_next) begin
        bus.pix_x   <= h_next - H_FIRST_PIX;
        bus.pix_y   <= v_next - V_FIRST_PIX;
        bus.pix_rgb <= rgb1;
      end
    end
  end
endmodule
